// File: rtl/crc_stream_engine.sv
// crc_stream_engine: bit-serial CRC over a valid/ready word stream framed by start/in_last, one message bit per clock.
// Optional CRC_CHECK_EN macro adds chk_value/crc_match to compare the final CRC against an expected value.
module crc_stream_engine #(
    parameter int               CRC_W  = 8,
    parameter logic [CRC_W-1:0] POLY   = 8'h9B,
    parameter logic [CRC_W-1:0] INIT   = '0,
    parameter logic [CRC_W-1:0] XOROUT = '0,
    parameter bit               REFIN  = 1'b0,
    parameter bit               REFOUT = 1'b0,
    parameter int               DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              ready,
    output logic              done,
`ifdef CRC_CHECK_EN
    input  logic [CRC_W-1:0]  chk_value,
    output logic              crc_match,
`endif
    output logic [CRC_W-1:0]  crc_result
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_FINAL} state_t;

    state_t             r_state, w_next;
    logic [CRC_W-1:0]   r_crc, r_result, w_crc_step, w_final;
    logic [DATA_W-1:0]  r_word;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_last, r_done, w_bit, w_fb, w_word_end, w_accept;

    function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
        return r;
    endfunction

    // The latched word is shifted toward the tap end, so the next message bit is always at a fixed position
    assign w_bit      = REFIN ? r_word[0] : r_word[DATA_W-1];
    assign w_fb       = r_crc[CRC_W-1] ^ w_bit;
    assign w_crc_step = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    assign w_final    = (REFOUT ? bitrev(r_crc) : r_crc) ^ XOROUT;
    assign w_word_end = r_bit_cnt == CNT_W'(DATA_W - 1);
    assign w_accept   = r_state == S_WAIT && in_valid && !start;

    assign ready      = r_state == S_IDLE;
    assign in_ready   = r_state == S_WAIT;
    assign done       = r_done;
    assign crc_result = r_result;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_WAIT : S_IDLE;
            S_WAIT:  w_next = start ? S_WAIT : (in_valid ? S_SHIFT : S_WAIT);
            S_SHIFT: w_next = start ? S_WAIT : (w_word_end ? (r_last ? S_FINAL : S_WAIT) : S_SHIFT);
            S_FINAL: w_next = start ? S_WAIT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_crc     <= INIT;
            r_word    <= '0;
            r_last    <= 1'b0;
            r_bit_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (start) begin
                r_crc     <= INIT;
                r_bit_cnt <= '0;
            end else if (w_accept) begin
                r_word    <= in_data;
                r_last    <= in_last;
                r_bit_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                r_crc     <= w_crc_step;
                r_word    <= REFIN ? r_word >> 1 : r_word << 1;
                r_bit_cnt <= w_word_end ? '0 : r_bit_cnt + 1'b1;
            end
        end
    end

    // A message finishing in FINAL still reports even if a new start arrives in that same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= r_state == S_FINAL;
            if (r_state == S_FINAL) r_result <= w_final;
        end
    end

`ifdef CRC_CHECK_EN
    logic r_match;

    assign crc_match = r_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_match <= 1'b0;
        else if (r_state == S_FINAL) r_match <= w_final == chk_value;
        else if (start) r_match <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: directed checks of crc_stream_engine against catalogue CRC check values.
// Three DATA_W=8 variants (CRC-8/LTE, CRC-16 0x1021, CRC-32) share one input bus; a DATA_W=16 variant has its own.
module tb_crc_stream_engine;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [7:0]  in_data = '0;
    logic        w_start = 1'b0, w_valid = 1'b0, w_last = 1'b0;
    logic [15:0] w_data = '0;

    logic        ready8, in_ready8, done8, ready16, in_ready16, done16;
    logic        ready32, in_ready32, done32, ready_w, in_ready_w, done_w;
    logic [7:0]  res8, res_w;
    logic [15:0] res16;
    logic [31:0] res32;

    int checks = 0, errors = 0, dcnt = 0, dcnt_w = 0;

`ifdef CRC_CHECK_EN
    logic [7:0]  chk8 = 8'hEA, chk_w = 8'h25;
    logic [15:0] chk16 = 16'h29B1;
    logic [31:0] chk32 = 32'hCBF43926;
    logic        match8, match16, match32, match_w;
`endif

    crc_stream_engine u8 (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready8), .ready(ready8), .done(done8),
`ifdef CRC_CHECK_EN
        .chk_value(chk8), .crc_match(match8),
`endif
        .crc_result(res8));

    crc_stream_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF)) u16 (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready16), .ready(ready16), .done(done16),
`ifdef CRC_CHECK_EN
        .chk_value(chk16), .crc_match(match16),
`endif
        .crc_result(res16));

    crc_stream_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF),
                        .REFIN(1'b1), .REFOUT(1'b1)) u32 (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready32), .ready(ready32), .done(done32),
`ifdef CRC_CHECK_EN
        .chk_value(chk32), .crc_match(match32),
`endif
        .crc_result(res32));

    crc_stream_engine #(.DATA_W(16)) uw (
        .clk(clk), .rst(rst), .start(w_start), .in_data(w_data), .in_valid(w_valid), .in_last(w_last),
        .in_ready(in_ready_w), .ready(ready_w), .done(done_w),
`ifdef CRC_CHECK_EN
        .chk_value(chk_w), .crc_match(match_w),
`endif
        .crc_result(res_w));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done8) dcnt++;
        if (done_w) dcnt_w++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // All drivers run at posedge+1 so inputs settle well before the next active edge
    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b, input logic l, input int gap);
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        in_data = b; in_valid = 1'b1; in_last = l;
        while (!in_ready8 && n < 50) begin @(posedge clk); #1; n++; end
        check("feed_ready", in_ready8, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        check("shift_in_ready", {in_ready8, in_ready16, in_ready32}, 3'b000);
    endtask

    task automatic feed_w(input logic [15:0] wd, input logic l, input int gap);
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        w_data = wd; w_valid = 1'b1; w_last = l;
        while (!in_ready_w && n < 50) begin @(posedge clk); #1; n++; end
        check("feed_w_ready", in_ready_w, 1);
        @(posedge clk); #1;
        w_valid = 1'b0; w_last = 1'b0;
        check("shift_w_in_ready", in_ready_w, 0);
    endtask

    task automatic send_str(input string s, input bit gapped);
        for (int i = 0; i < s.len(); i++) feed(s[i], i == s.len() - 1, gapped ? i % 6 : 0);
    endtask

    task automatic wait_done;
        int n = 0;
        while (!done8 && n < 100) begin @(posedge clk); #1; n++; end
        check("done_seen", done8, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, saved;
        #1 rst = 1'b1;
        #2;
        check("rst_ready", {ready8, ready16, ready32, ready_w}, 4'b1111);
        check("rst_in_ready", {in_ready8, in_ready16, in_ready32, in_ready_w}, 4'b0000);
        check("rst_done", {done8, done16, done32, done_w}, 4'b0000);
        check("rst_res8", res8, 8'h00);
        check("rst_res16", res16, 16'h0000);
        check("rst_res32", res32, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        in_data = 8'h31; in_valid = 1'b1; in_last = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("idle_in_ready", in_ready8, 0);
        check("idle_ready", ready8, 1);
        in_valid = 1'b0; in_last = 1'b0;

        // Gapless "123456789" with exact latency: done rises 9 edges after the last word is taken
        pulse_start;
        check("wait_ready", ready8, 0);
        send_str("123456789", 1'b0);
        repeat (8) begin @(posedge clk); #1; end
        check("lat_early", done8, 0);
        @(posedge clk); #1;
        check("lat_done", {done8, done16, done32}, 3'b111);
        check("crc8", res8, 8'hEA);
        check("crc16", res16, 16'h29B1);
        check("crc32", res32, 32'hCBF43926);
`ifdef CRC_CHECK_EN
        check("match_hit", {match8, match16, match32}, 3'b111);
        chk8 = 8'hEB;
`endif
        @(posedge clk); #1;
        check("done_pulse", done8, 0);
        check("idle_after", ready8, 1);
        check("done_cnt1", dcnt, 1);

        // Same message with 0..5 idle cycles before each word
        pulse_start;
`ifdef CRC_CHECK_EN
        check("match_clr", match8, 0);
`endif
        send_str("123456789", 1'b1);
        wait_done;
        check("gap_crc8", res8, 8'hEA);
        check("gap_crc16", res16, 16'h29B1);
        check("gap_crc32", res32, 32'hCBF43926);
`ifdef CRC_CHECK_EN
        check("match_miss", match8, 0);
        chk8 = 8'hEA;
`endif
        @(posedge clk); #1;
        check("done_cnt2", dcnt, 2);

        // Abort after 4 bytes while shifting, then a full message
        pulse_start;
        for (int i = 0; i < 4; i++) feed(8'h31 + 8'(i), 1'b0, 0);
        pulse_start;
        check("abort_wait", in_ready8, 1);
        send_str("123456789", 1'b0);
        wait_done;
        check("abort_crc8", res8, 8'hEA);
        check("abort_crc16", res16, 16'h29B1);
        check("abort_crc32", res32, 32'hCBF43926);
        @(posedge clk); #1;
        check("done_cnt3", dcnt, 3);

        // "12345678" bytewise: CRC-8/LTE of eight bytes is 0x25
        pulse_start;
        send_str("12345678", 1'b0);
        wait_done;
        check("crc8_8b", res8, 8'h25);

        // Same eight bytes as four 16-bit words, with gaps
        w_start = 1'b1;
        @(posedge clk); #1;
        w_start = 1'b0;
        feed_w(16'h3132, 1'b0, 0);
        feed_w(16'h3334, 1'b0, 3);
        feed_w(16'h3536, 1'b0, 1);
        feed_w(16'h3738, 1'b1, 5);
        n = 0;
        while (!done_w && n < 100) begin @(posedge clk); #1; n++; end
        check("w_done_seen", done_w, 1);
        check("w_crc", res_w, 8'h25);
`ifdef CRC_CHECK_EN
        check("w_match", match_w, 1);
`endif
        @(posedge clk); #1;
        check("w_done_cnt", dcnt_w, 1);
        check("w_idle", ready_w, 1);

        // Asynchronous reset in the middle of a word
        saved = dcnt;
        pulse_start;
        feed(8'h31, 1'b1, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", ready8, 1);
        check("mid_rst_res8", res8, 8'h00);
        check("mid_rst_res16", res16, 16'h0000);
        check("mid_rst_done", done8, 0);
        check("mid_rst_in_ready", in_ready8, 0);
        #1 rst = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        check("mid_rst_no_done", dcnt, saved);
        check("mid_rst_idle", ready8, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
